spi_master_arb: RTL and testbench

SPI_MASTER_ARB -- requirements
Module: spi_master_arb

---
 rtl/spi_master_arb.sv | 212 +++++++++++++++++++++
 tb/tb_spi_master_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arb.sv
// Two-requester SPI mode-0 master: arbitrates req[1:0], shifts one DATA_W frame MSB first, returns the captured word.
// Define SPI_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module spi_master_arb #(
   parameter int DATA_W = 8,
   parameter int CLKDIV = 2
) (
   input  logic              sclk,
   input  logic              i_reset_n,
   input  logic [1:0]        req,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_id,
   output logic              busy,
   output logic              cs,
   output logic              spi_sck,
   output logic              mosi,
   input  logic              miso
);

   localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              r_state;
   logic [1:0]          r_gnt;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_data;
   logic                r_rsp_id;
   logic                r_busy;
   logic                r_cs;
   logic                r_sck;
   logic [DATA_W-1:0]   r_tx;
   logic [DATA_W-1:0]   r_rx;
   logic [DIV_W-1:0]    r_div;
   logic [BIT_W-1:0]    r_bit;
   logic                r_owner;

   state_t              w_state_nx;
   logic [1:0]          w_gnt_nx;
   logic                w_rsp_valid_nx;
   logic [DATA_W-1:0]   w_rsp_data_nx;
   logic                w_rsp_id_nx;
   logic                w_busy_nx;
   logic                w_cs_nx;
   logic                w_sck_nx;
   logic [DATA_W-1:0]   w_tx_nx;
   logic [DATA_W-1:0]   w_rx_nx;
   logic [DIV_W-1:0]    w_div_nx;
   logic [BIT_W-1:0]    w_bit_nx;
   logic                w_owner_nx;
   logic                w_pick;
   logic [DATA_W-1:0]   w_word;

`ifdef SPI_ARB_RR_EN
   logic                r_prio;
   logic                w_prio_nx;
`endif

   // Requester selection; only consulted while IDLE.
   always_comb begin
      w_pick = 1'b0;
`ifdef SPI_ARB_RR_EN
      if (req == 2'b11) begin
         w_pick = r_prio;
      end else begin
         w_pick = ~req[0];
      end
`else
      w_pick = ~req[0];
`endif
      w_word = w_pick ? wdata1 : wdata0;
   end

   // Next-state and next-output logic for the frame FSM.
   always_comb begin
      w_state_nx     = r_state;
      w_gnt_nx       = 2'b00;
      w_rsp_valid_nx = 1'b0;
      w_rsp_data_nx  = r_rsp_data;
      w_rsp_id_nx    = r_rsp_id;
      w_busy_nx      = r_busy;
      w_cs_nx        = r_cs;
      w_sck_nx       = r_sck;
      w_tx_nx        = r_tx;
      w_rx_nx        = r_rx;
      w_div_nx       = r_div;
      w_bit_nx       = r_bit;
      w_owner_nx     = r_owner;
`ifdef SPI_ARB_RR_EN
      w_prio_nx      = r_prio;
`endif
      case (r_state)
         S_IDLE: begin
            w_busy_nx = 1'b0;
            w_cs_nx   = 1'b1;
            w_sck_nx  = 1'b0;
            if (req != 2'b00) begin
               w_state_nx = S_SHIFT;
               w_gnt_nx   = w_pick ? 2'b10 : 2'b01;
               w_owner_nx = w_pick;
               w_tx_nx    = w_word;
               w_rx_nx    = {DATA_W{1'b0}};
               w_div_nx   = {DIV_W{1'b0}};
               w_bit_nx   = {BIT_W{1'b0}};
               w_busy_nx  = 1'b1;
               w_cs_nx    = 1'b0;
`ifdef SPI_ARB_RR_EN
               w_prio_nx  = ~w_pick;
`endif
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (r_div == DIV_LAST) begin
               w_div_nx = {DIV_W{1'b0}};
               if (!r_sck) begin
                  // Rising spi_sck edge: capture miso.
                  w_sck_nx = 1'b1;
                  w_rx_nx  = {r_rx[DATA_W-2:0], miso};
               end else begin
                  w_sck_nx = 1'b0;
                  if (r_bit == BIT_LAST) begin
                     w_state_nx     = S_DONE;
                     w_cs_nx        = 1'b1;
                     w_rsp_valid_nx = 1'b1;
                     w_rsp_data_nx  = r_rx;
                     w_rsp_id_nx    = r_owner;
                     w_tx_nx        = {DATA_W{1'b0}};
                  end else begin
                     w_bit_nx = r_bit + BIT_W'(1);
                     w_tx_nx  = {r_tx[DATA_W-2:0], 1'b0};
                  end
               end
            end else begin
               w_div_nx = r_div + DIV_W'(1);
            end
         end
         S_DONE: begin
            w_state_nx = S_IDLE;
            w_busy_nx  = 1'b0;
            w_cs_nx    = 1'b1;
            w_sck_nx   = 1'b0;
         end
         default: begin
            w_state_nx = S_IDLE;
            w_busy_nx  = 1'b0;
            w_cs_nx    = 1'b1;
            w_sck_nx   = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge sclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= S_IDLE;
         r_gnt       <= 2'b00;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= {DATA_W{1'b0}};
         r_rsp_id    <= 1'b0;
         r_busy      <= 1'b0;
         r_cs        <= 1'b1;
         r_sck       <= 1'b0;
         r_tx        <= {DATA_W{1'b0}};
         r_rx        <= {DATA_W{1'b0}};
         r_div       <= {DIV_W{1'b0}};
         r_bit       <= {BIT_W{1'b0}};
         r_owner     <= 1'b0;
`ifdef SPI_ARB_RR_EN
         r_prio      <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nx;
         r_gnt       <= w_gnt_nx;
         r_rsp_valid <= w_rsp_valid_nx;
         r_rsp_data  <= w_rsp_data_nx;
         r_rsp_id    <= w_rsp_id_nx;
         r_busy      <= w_busy_nx;
         r_cs        <= w_cs_nx;
         r_sck       <= w_sck_nx;
         r_tx        <= w_tx_nx;
         r_rx        <= w_rx_nx;
         r_div       <= w_div_nx;
         r_bit       <= w_bit_nx;
         r_owner     <= w_owner_nx;
`ifdef SPI_ARB_RR_EN
         r_prio      <= w_prio_nx;
`endif
      end
   end

   assign gnt       = r_gnt;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;
   assign busy      = r_busy;
   assign cs        = r_cs;
   assign spi_sck   = r_sck;
   assign mosi      = r_tx[DATA_W-1];

endmodule

// File: tb/tb_spi_master_arb.sv
// Bench for spi_master_arb: a CLKDIV=2 instance with a mode-0 slave model, plus a CLKDIV=1 loopback instance.
module tb_spi_master_arb;

   localparam int W     = 8;
   localparam int C     = 2;
   localparam int FRAME = 2 * C * W;
`ifdef SPI_ARB_RR_EN
   localparam logic RR = 1'b1;
`else
   localparam logic RR = 1'b0;
`endif

   logic         sclk  = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   req   = 2'b00;
   logic [W-1:0] wdata0 = '0;
   logic [W-1:0] wdata1 = '0;
   logic         miso  = 1'b0;
   logic [1:0]   gnt;
   logic         rsp_valid;
   logic [W-1:0] rsp_data;
   logic         rsp_id, busy, cs, spi_sck, mosi;

   logic [1:0]   req_b    = 2'b00;
   logic [W-1:0] wdata0_b = '0;
   logic [W-1:0] wdata1_b = '0;
   logic         miso_b;
   logic [1:0]   gnt_b;
   logic         rsp_valid_b;
   logic [W-1:0] rsp_data_b;
   logic         rsp_id_b, busy_b, cs_b, spi_sck_b, mosi_b;

   int checks = 0;
   int errors = 0;
   int n_gnt  = 0;
   int n_rsp  = 0;

   logic [W-1:0] s_word = '0;
   logic [W-1:0] cap    = '0;
   int           s_idx  = 0;
   int           pulses = 0;
   logic         prev_cs  = 1'b1;
   logic         prev_sck = 1'b0;
   logic         m_ptr    = 1'b0;

   spi_master_arb #(.DATA_W(W), .CLKDIV(C)) u_dut (
      .sclk(sclk), .i_reset_n(rst_n), .req(req), .wdata0(wdata0), .wdata1(wdata1),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .busy(busy), .cs(cs), .spi_sck(spi_sck), .mosi(mosi), .miso(miso)
   );

   spi_master_arb #(.DATA_W(W), .CLKDIV(1)) u_dut_b (
      .sclk(sclk), .i_reset_n(rst_n), .req(req_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
      .gnt(gnt_b), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_id(rsp_id_b),
      .busy(busy_b), .cs(cs_b), .spi_sck(spi_sck_b), .mosi(mosi_b), .miso(miso_b)
   );

   assign miso_b = mosi_b;

   always #5 sclk = ~sclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arbitration reference: requester 0 wins ties unless round-robin hands the tie to the pointer.
   function automatic logic arb(input logic [1:0] r);
      if (RR && r == 2'b11) return m_ptr;
      return r[0] ? 1'b0 : 1'b1;
   endfunction

   // Mode-0 slave: presents the MSB when selected, next bit after each falling sck, records mosi on rising sck.
   always @(posedge sclk) begin
      #1;
      if (!cs && prev_cs) begin
         s_idx  = W - 1;
         miso   = s_word[W-1];
         cap    = '0;
         pulses = 0;
      end else if (!cs && prev_sck && !spi_sck && s_idx > 0) begin
         s_idx = s_idx - 1;
         miso  = s_word[s_idx];
      end
      if (!cs && !prev_sck && spi_sck) begin
         cap = {cap[W-2:0], mosi};
         pulses++;
      end
      if (gnt != 2'b00) begin
         n_gnt++;
         check("gnt_onehot", {31'd0, $onehot(gnt)}, 32'd1);
      end
      if (rsp_valid) n_rsp++;
      prev_cs  = cs;
      prev_sck = spi_sck;
   end

   task automatic do_frame(input logic [1:0] r, input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [W-1:0] sw, input logic exp_id, input int pulse_off);
      logic [W-1:0] tx;
      wdata0 = w0;
      wdata1 = w1;
      s_word = sw;
      req    = r;
      tx     = exp_id ? w1 : w0;
      @(posedge sclk); #1;
      check("gnt", gnt, exp_id ? 2'b10 : 2'b01);
      check("grant_cyc", {busy, cs, spi_sck, mosi}, {1'b1, 1'b0, 1'b0, tx[W-1]});
      for (int t = 1; t < FRAME; t++) begin
         if (t == pulse_off) req = r | 2'b10;
         else if (t == pulse_off + 1) req = r;
         @(posedge sclk); #1;
         check("frame_cyc", {rsp_valid, gnt, cs, busy, spi_sck, mosi},
               {1'b0, 2'b00, 1'b0, 1'b1, 1'((t / C) % 2), tx[W - 1 - t / (2 * C)]});
      end
      @(posedge sclk); #1;
      check("done_ctl", {rsp_valid, cs, spi_sck, busy}, 4'b1101);
      check("rsp_data", rsp_data, sw);
      check("rsp_id", rsp_id, exp_id);
      check("mosi_word", cap, tx);
      check("sck_pulses", pulses, W);
      @(posedge sclk); #1;
      check("post_done", {rsp_valid, busy, cs}, 3'b001);
   endtask

   typedef struct {
      logic [1:0]   r;
      logic [W-1:0] w0;
      logic [W-1:0] w1;
      logic [W-1:0] sw;
      logic         exp_id;
      int           pulse;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{2'b11, 8'h11, 8'h22, 8'h5A, 1'b0, -1};
      tbl[1] = '{2'b11, 8'h33, 8'h44, 8'h96, RR,   -1};
      tbl[2] = '{2'b11, 8'h55, 8'h66, 8'hE7, 1'b0, -1};
      tbl[3] = '{2'b01, 8'hA5, 8'h00, 8'h3C, 1'b0,  7};
      tbl[4] = '{2'b11, 8'h0F, 8'hF0, 8'h01, RR,   -1};
      tbl[5] = '{2'b10, 8'h00, 8'hC3, 8'h81, 1'b1, -1};
      tbl[6] = '{2'b01, 8'h80, 8'h7E, 8'hFE, 1'b0, -1};
      tbl[7] = '{2'b11, 8'h69, 8'h96, 8'h42, RR,   -1};

      repeat (3) @(posedge sclk);
      #1;
      check("rst_ctl", {gnt, rsp_valid, busy, cs, spi_sck, mosi, rsp_id}, {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      check("rst_data", rsp_data, 0);
      check("rst_b", {gnt_b, busy_b, cs_b, spi_sck_b}, 5'b00010);
      rst_n = 1'b1;
      @(posedge sclk); #1;

      for (int i = 0; i < 8; i++) begin
         do_frame(tbl[i].r, tbl[i].w0, tbl[i].w1, tbl[i].sw, tbl[i].exp_id, tbl[i].pulse);
         m_ptr = ~tbl[i].exp_id;
      end

      for (int i = 0; i < 24; i++) begin
         logic [1:0]   r;
         logic         pick;
         int           gap;
         int           poff;
         r    = 2'($urandom_range(1, 3));
         gap  = $urandom_range(0, 2);
         poff = (r == 2'b01 && $urandom_range(0, 1) == 1) ? $urandom_range(2, FRAME - 3) : -1;
         req  = 2'b00;
         for (int g = 0; g < gap; g++) begin
            @(posedge sclk); #1;
            check("idle", {cs, busy, spi_sck, rsp_valid, gnt}, 6'b100000);
         end
         pick = arb(r);
         do_frame(r, W'($urandom), W'($urandom), W'($urandom), pick, poff);
         m_ptr = ~pick;
      end

      req    = 2'b01;
      wdata0 = 8'hC6;
      s_word = 8'h5F;
      @(posedge sclk); #1;
      check("abort_gnt", gnt, 2'b01);
      req = 2'b00;
      for (int t = 1; t <= 10; t++) begin
         @(posedge sclk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("abort_now", {cs, spi_sck, busy, gnt, rsp_valid, mosi}, 7'b1000000);
      @(posedge sclk); #1;
      rst_n = 1'b1;
      m_ptr = 1'b0;
      for (int t = 0; t < 2 * FRAME; t++) begin
         @(posedge sclk); #1;
         check("abort_quiet", {rsp_valid, cs, busy}, 3'b010);
      end
      do_frame(2'b10, 8'h00, 8'h9B, 8'hD4, 1'b1, -1);
      req = 2'b00;

      begin
         int n_hi;
         req_b    = 2'b10;
         wdata1_b = 8'hFF;
         @(posedge sclk); #1;
         check("b_gnt0", gnt_b, 2'b10);
         req_b = 2'b00;
         for (int t = 1; t < 16; t++) begin
            @(posedge sclk); #1;
            check("b_shift0", {rsp_valid_b, cs_b}, 2'b00);
         end
         @(posedge sclk); #1;
         check("b_done0", {rsp_valid_b, cs_b, rsp_id_b}, 3'b111);
         check("b_data0", rsp_data_b, 8'hFF);
         wdata1_b = 8'h00;
         req_b    = 2'b10;
         n_hi     = 1;
         for (int t = 0; t < 10 && cs_b; t++) begin
            @(posedge sclk); #1;
            if (cs_b) n_hi++;
         end
         check("b_cs_gap", {31'd0, n_hi >= 2}, 32'd1);
         check("b_gnt1", gnt_b, 2'b10);
         req_b = 2'b00;
         for (int t = 1; t < 16; t++) begin
            @(posedge sclk); #1;
            check("b_shift1", {rsp_valid_b, cs_b}, 2'b00);
         end
         @(posedge sclk); #1;
         check("b_done1", {rsp_valid_b, cs_b}, 2'b11);
         check("b_data1", rsp_data_b, 8'h00);
      end

      repeat (2) @(posedge sclk);
      #2;
      check("rsp_per_gnt", n_rsp, n_gnt - 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
